// File: rtl/aes_stream_cipher.sv
`default_nettype none
// ============================================================================
// Module   : aes_stream_cipher (with helper core aes_encrypt)
// Purpose  : Pipelined AES-128 streaming encryption engine supporting ECB,
//            CBC and CTR. Blocks are queued in an input FIFO and issued
//            through one combinational AES-128 core, then through LAT
//            register stages. Output backpressure stalls the whole pipe.
// Ports    : clk, rst (async, active-high)
//            cfg_load_i/cfg_key_i/cfg_iv_i/cfg_mode_i : configuration strobe
//            cfg_err_o                                : rejected-config pulse
//            in_valid_i/in_ready_o/in_data_i          : plaintext stream
//            out_valid_o/out_ready_i/out_data_o       : ciphertext stream
//            busy_o                                   : queued or in-flight work
//            blk_cnt_o                                : completed output blocks
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// aes_encrypt: fully combinational AES-128 encryption (10 rounds, on-the-fly
// key schedule). Byte 0 of the state is bits [127:120]; column-major layout.
// ----------------------------------------------------------------------------
module aes_encrypt (
  input  logic [127:0] key_i,
  input  logic [127:0] pt_i,
  output logic [127:0] ct_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from first principles: inverse is a^254 = a^2*a^4*...*a^128
  // (zero maps to zero naturally), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sbox(st[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] st);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127-32*c -: 8];
      a1 = st[119-32*c -: 8];
      a2 = st[111-32*c -: 8];
      a3 = st[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] st;
  logic [127:0] rk;
  logic [7:0]   rcon;

  always_comb begin
    st   = pt_i ^ key_i;
    rk   = key_i;
    rcon = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      rk   = key_next(rk, rcon);
      rcon = xtime(rcon);
      st   = sub_shift(st);
      if (rnd != 10) st = mix_cols(st);
      st   = st ^ rk;
    end
    ct_o = st;
  end

endmodule

// ----------------------------------------------------------------------------
// aes_stream_cipher: top level
// ----------------------------------------------------------------------------
module aes_stream_cipher #(
  parameter int IN_DEPTH = 4,
  parameter int LAT      = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load_i,
  input  logic [127:0]     cfg_key_i,
  input  logic [127:0]     cfg_iv_i,
  input  logic [1:0]       cfg_mode_i,
  output logic             cfg_err_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  localparam int PW = $clog2(IN_DEPTH);
  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  logic [127:0]     key_q, key_d;
  logic [127:0]     chain_q, chain_d;
  logic [127:0]     ctr_q, ctr_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [127:0]     mem_q [IN_DEPTH];
  logic [127:0]     s_q [LAT];
  logic [127:0]     s_d [LAT];
  logic [LAT-1:0]   v_q, v_d;

  logic             fifo_empty, fifo_full;
  logic [127:0]     head;
  logic             stall, issue, push, cfg_ok;
  logic [127:0]     core_in, core_out, stage_in;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head       = mem_q[rd_ptr_q[PW-1:0]];

  assign busy_o      = !fifo_empty || (|v_q);
  assign in_ready_o  = !fifo_full && !cfg_load_i;
  assign out_valid_o = v_q[LAT-1];
  assign out_data_o  = s_q[LAT-1];
  assign cfg_err_o   = cfg_err_q;
  assign blk_cnt_o   = blk_cnt_q;

  assign stall  = v_q[LAT-1] && !out_ready_i;
  assign issue  = !stall && !fifo_empty;
  assign push   = in_valid_i && in_ready_o;
  assign cfg_ok = cfg_load_i && !busy_o && (cfg_mode_i != MODE_RSV);

  always_comb begin
    core_in  = head;
    stage_in = core_out;
    case (mode_q)
      MODE_CBC: core_in = head ^ chain_q;
      MODE_CTR: begin
        core_in  = ctr_q;
        stage_in = core_out ^ head;
      end
      default: ;
    endcase
  end

  aes_encrypt u_core (
    .key_i (key_q),
    .pt_i  (core_in),
    .ct_o  (core_out)
  );

  always_comb begin
    key_d     = key_q;
    chain_d   = chain_q;
    ctr_d     = ctr_q;
    mode_d    = mode_q;
    blk_cnt_d = blk_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    s_d       = s_q;
    v_d       = v_q;
    cfg_err_d = cfg_load_i && !cfg_ok;

    if (cfg_ok) begin
      key_d     = cfg_key_i;
      chain_d   = cfg_iv_i;
      ctr_d     = cfg_iv_i;
      mode_d    = cfg_mode_i;
      blk_cnt_d = '0;
    end else if (out_valid_o && out_ready_i) begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end

    if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

    // Chain/counter advance at issue time, so consecutive issues see the
    // previous block's result within the same combinational core.
    if (issue && (mode_q == MODE_CBC)) chain_d = core_out;
    if (issue && (mode_q == MODE_CTR)) ctr_d = {ctr_q[127:32], ctr_q[31:0] + 32'd1};

    if (!stall) begin
      for (int i = LAT - 1; i >= 1; i--) begin
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
      v_d[0] = issue;
      if (issue) s_d[0] = stage_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      chain_q   <= '0;
      ctr_q     <= '0;
      mode_q    <= MODE_ECB;
      blk_cnt_q <= '0;
      cfg_err_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      v_q       <= '0;
      for (int i = 0; i < LAT; i++) s_q[i] <= '0;
    end else begin
      key_q     <= key_d;
      chain_q   <= chain_d;
      ctr_q     <= ctr_d;
      mode_q    <= mode_d;
      blk_cnt_q <= blk_cnt_d;
      cfg_err_q <= cfg_err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      v_q       <= v_d;
      s_q       <= s_d;
    end
  end

  // Storage array needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= in_data_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_cipher.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_stream_cipher
// Purpose  : Self-checking bench for aes_stream_cipher. A byte-array AES-128
//            reference plus a scoreboard queue predicts every output block;
//            directed sections pin latency, chaining, counter wrap,
//            backpressure, config rejection and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_stream_cipher;

  localparam int IN_DEPTH = 4;
  localparam int LAT      = 2;
  localparam int CNT_W    = 32;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2A = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2A = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2B = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_load_i = 1'b0;
  logic [127:0]     cfg_key_i = '0;
  logic [127:0]     cfg_iv_i = '0;
  logic [1:0]       cfg_mode_i = 2'b00;
  logic             cfg_err_o;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [127:0]     in_data_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [127:0]     out_data_o;
  logic             busy_o;
  logic [CNT_W-1:0] blk_cnt_o;

  aes_stream_cipher #(.IN_DEPTH(IN_DEPTH), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_load_i(cfg_load_i), .cfg_key_i(cfg_key_i), .cfg_iv_i(cfg_iv_i),
    .cfg_mode_i(cfg_mode_i), .cfg_err_o(cfg_err_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference AES-128 ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x, y;
    r = 0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 0;
      for (int b = 1; b < 256; b++)
        if (gm(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   tmp [16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ key[127-8*k -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) tmp[rr+4*c] = s[rr+4*((c+rr)%4)];
      for (int k = 0; k < 16; k++) s[k] = tmp[k];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          tmp[4*c]   = gm(s[4*c], 2) ^ gm(s[4*c+1], 3) ^ s[4*c+2] ^ s[4*c+3];
          tmp[4*c+1] = s[4*c] ^ gm(s[4*c+1], 2) ^ gm(s[4*c+2], 3) ^ s[4*c+3];
          tmp[4*c+2] = s[4*c] ^ s[4*c+1] ^ gm(s[4*c+2], 2) ^ gm(s[4*c+3], 3);
          tmp[4*c+3] = gm(s[4*c], 3) ^ s[4*c+1] ^ s[4*c+2] ^ gm(s[4*c+3], 2);
        end
        for (int k = 0; k < 16; k++) s[k] = tmp[k];
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // ---------------- scoreboard / engine model ----------------
  logic [127:0] q [$];
  logic [127:0] m_key, m_chain, m_ctr, e;
  logic [1:0]   m_mode;
  logic [CNT_W-1:0] m_cnt;
  logic         exp_err = 1'b0;
  logic         m_busy;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_key = '0; m_chain = '0; m_ctr = '0; m_mode = 2'b00; m_cnt = '0;
      exp_err = 1'b0;
    end else begin
      m_busy = (q.size() != 0);
      check("cfg_err", cfg_err_o, exp_err);
      check("busy", busy_o, m_busy);
      check("blk_cnt", blk_cnt_o, m_cnt);
      if (cfg_load_i) check("ready_during_cfg", in_ready_o, 1'b0);
      if (out_valid_o) begin
        if (q.size() == 0) check("out_when_empty", out_valid_o, 1'b0);
        else begin
          check("out_data", out_data_o, q[0]);
          if (out_ready_i) begin
            void'(q.pop_front());
            m_cnt = m_cnt + 1'b1;
          end
        end
      end
      exp_err = cfg_load_i && (m_busy || cfg_mode_i == 2'b11);
      if (cfg_load_i && !exp_err) begin
        m_key = cfg_key_i; m_chain = cfg_iv_i; m_ctr = cfg_iv_i;
        m_mode = cfg_mode_i; m_cnt = '0;
      end
      if (in_valid_i && in_ready_o) begin
        case (m_mode)
          2'b01: begin e = aes_ref(m_key, in_data_i ^ m_chain); m_chain = e; end
          2'b10: begin
            e = aes_ref(m_key, m_ctr) ^ in_data_i;
            m_ctr[31:0] = m_ctr[31:0] + 32'd1;
          end
          default: e = aes_ref(m_key, in_data_i);
        endcase
        q.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [127:0] k, input logic [127:0] iv, input logic [1:0] m);
    cfg_load_i = 1'b1; cfg_key_i = k; cfg_iv_i = iv; cfg_mode_i = m;
    cyc();
    cfg_load_i = 1'b0;
  endtask

  task automatic push1(input logic [127:0] d);
    in_valid_i = 1'b1; in_data_i = d;
    cyc();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    check("drain_idle", busy_o, 1'b0);
    cyc();
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_o) break;
    end
    check(name, out_valid_o, 1'b1);
  endtask

  logic [127:0] held;

  initial begin
    init_sbox();
    check("model_fips", aes_ref(K1, P1), C1);
    check("model_zero", aes_ref('0, '0), CZ);
    check("model_cbc0", aes_ref(K2, P2A ^ IV2), C2A);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_data", out_data_o, '0);
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cfg_err", cfg_err_o, 1'b0);
    check("rst_blk_cnt", blk_cnt_o, '0);
    rst = 1'b0;
    cyc();

    // ECB FIPS-197 with latency check
    cfg(K1, '0, 2'b00);
    push1(P1);
    @(negedge clk); check("ecb_lat0", out_valid_o, 1'b0);
    @(negedge clk); check("ecb_lat1", out_valid_o, 1'b0);
    @(negedge clk); check("ecb_lat2", out_valid_o, 1'b1);
    check("ecb_fips", out_data_o, C1);
    @(negedge clk); check("ecb_cnt", blk_cnt_o, 1);
    wait_idle();

    // CBC SP800-38A back-to-back
    cfg(K2, IV2, 2'b01);
    in_valid_i = 1'b1; in_data_i = P2A; cyc();
    in_data_i = P2B; cyc();
    in_valid_i = 1'b0;
    wait_valid("cbc_valid0");
    check("cbc_blk0", out_data_o, C2A);
    @(negedge clk);
    check("cbc_valid1", out_valid_o, 1'b1);
    check("cbc_blk1", out_data_o, C2B);
    wait_idle();

    // CTR low-word wrap
    cfg(K2, 128'h000000000000000000000000ffffffff, 2'b10);
    in_valid_i = 1'b1; in_data_i = P2A; cyc();
    in_data_i = P2B; cyc();
    in_valid_i = 1'b0;
    wait_valid("ctr_valid0");
    check("ctr_blk0", out_data_o, aes_ref(K2, 128'h000000000000000000000000ffffffff) ^ P2A);
    @(negedge clk);
    check("ctr_blk1", out_data_o, aes_ref(K2, '0) ^ P2B);
    wait_idle();

    // Backpressure: fill pipeline and FIFO, then drain
    cfg(K1, '0, 2'b00);
    out_ready_i = 1'b0;
    for (int k = 0; k < IN_DEPTH + LAT; k++) begin
      in_valid_i = 1'b1; in_data_i = {4{32'hA5000000 + k}};
      @(negedge clk); check("bp_ready_open", in_ready_o, 1'b1);
      cyc();
    end
    in_data_i = 128'hdeadbeef;
    @(negedge clk);
    check("bp_ready_full", in_ready_o, 1'b0);
    held = out_data_o;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid_o, 1'b1);
      check("bp_hold_data", out_data_o, held);
      check("bp_hold_ready", in_ready_o, 1'b0);
    end
    cyc();
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int k = 0; k < IN_DEPTH + LAT; k++) begin
      @(negedge clk); check("bp_drain_rate", out_valid_o, 1'b1);
    end
    @(negedge clk); check("bp_drain_end", out_valid_o, 1'b0);
    wait_idle();

    // Config rejection while busy, reserved mode, cfg with data
    out_ready_i = 1'b0;
    push1(P1);
    cfg(K2, IV2, 2'b10);
    @(negedge clk); check("cfg_busy_err", cfg_err_o, 1'b1);
    cyc();
    out_ready_i = 1'b1;
    wait_idle();
    cfg(K2, IV2, 2'b11);
    @(negedge clk); check("cfg_rsv_err", cfg_err_o, 1'b1);
    cyc();
    push1(P1);
    wait_valid("cfg_keep_valid");
    check("cfg_keep_key", out_data_o, C1);
    wait_idle();
    cfg_load_i = 1'b1; cfg_key_i = K1; cfg_iv_i = '0; cfg_mode_i = 2'b00;
    in_valid_i = 1'b1; in_data_i = P2A;
    #1; check("cfg_blocks_in", in_ready_o, 1'b0);
    cyc();
    cfg_load_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk); check("cfg_no_push", busy_o, 1'b0);
    cyc();

    // Async reset with blocks in flight
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin in_data_i = {4{32'h11110000 + k}}; cyc(); end
    in_valid_i = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid_o, 1'b0);
    check("arst_out_data", out_data_o, '0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_in_ready", in_ready_o, 1'b1);
    check("arst_blk_cnt", blk_cnt_o, '0);
    @(posedge clk); #3;
    rst = 1'b0; out_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); check("arst_silent", out_valid_o, 1'b0);
    end
    cyc();
    push1('0);
    wait_valid("arst_next_valid");
    check("arst_key0", out_data_o, CZ);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
